instr_fetch: RTL and testbench

//   Fetch/issue stage directly upstream of the pratica2 datapath. Reads

---
 rtl/instr_fetch.sv | 185 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch/issue stage feeding the pratica2 datapath. Reads a synchronous
// program ROM, latches IR (and the mvi immediate), pulses run and waits for done.
module instr_fetch #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter logic [2:0]  MVI_OP  = 3'b001,
  parameter logic [2:0]  HALT_OP = 3'b111,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [8:0]        ir,
  output logic [DATA_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              error
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
  // Wait counter starts at 0 in the first WAIT cycle, so done is accepted for
  // TIMEOUT-1 WAIT cycles and error becomes visible TIMEOUT cycles after ISSUE.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_IMM    = 3'd3,
    ST_IMM_LT = 3'd4,
    ST_ISSUE  = 3'd5,
    ST_WAIT   = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [ADDR_W-1:0] pc_r;
  logic [8:0]        ir_r;
  logic [DATA_W-1:0] din_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              run_r;
  logic              halted_r;
  logic              error_r;
  logic [2:0]        opcode_s;
  logic              load_ir_s;
  logic              load_din_s;
  logic              inc_pc_s;
  logic              clr_cnt_s;
  logic              inc_cnt_s;
  logic              set_halt_s;
  logic              set_err_s;

  assign opcode_s = mem_data[DATA_W-1 -: 3];

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    next_state_s = state_r;
    load_ir_s    = 1'b0;
    load_din_s   = 1'b0;
    inc_pc_s     = 1'b0;
    clr_cnt_s    = 1'b0;
    inc_cnt_s    = 1'b0;
    set_halt_s   = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        next_state_s = ST_LATCH;
      end
      ST_LATCH: begin
        load_ir_s = 1'b1;
        inc_pc_s  = 1'b1;
        if (opcode_s == HALT_OP) begin
          set_halt_s   = 1'b1;
          next_state_s = ST_HALT;
        end else if (opcode_s == MVI_OP) begin
          next_state_s = ST_IMM;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_IMM: begin
        next_state_s = ST_IMM_LT;
      end
      ST_IMM_LT: begin
        load_din_s   = 1'b1;
        inc_pc_s     = 1'b1;
        next_state_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        clr_cnt_s = 1'b1;
        if (done) begin
          next_state_s = enable ? ST_FETCH : ST_IDLE;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done) begin
          next_state_s = enable ? ST_FETCH : ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          set_err_s    = 1'b1;
          set_halt_s   = 1'b1;
          next_state_s = ST_HALT;
        end else begin
          inc_cnt_s    = 1'b1;
          next_state_s = ST_WAIT;
        end
      end
      ST_HALT: begin
        next_state_s = ST_HALT;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Program counter, instruction/immediate latches, wait counter and flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_r     <= {ADDR_W{1'b0}};
      ir_r     <= 9'h000;
      din_r    <= {DATA_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      run_r    <= 1'b0;
      halted_r <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      // run is registered off the next state so it is high exactly in ISSUE.
      run_r <= (next_state_s == ST_ISSUE);
      if (inc_pc_s) begin
        pc_r <= pc_r + PC_ONE;
      end
      if (load_ir_s) begin
        ir_r <= mem_data[DATA_W-1 -: 9];
      end
      if (load_din_s) begin
        din_r <= mem_data;
      end
      if (clr_cnt_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (inc_cnt_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (set_halt_s) begin
        halted_r <= 1'b1;
      end
      if (set_err_s) begin
        error_r <= 1'b1;
      end
    end
  end

  assign mem_addr = pc_r;
  assign pc       = pc_r;
  assign ir       = ir_r;
  assign din      = din_r;
  assign run      = run_r;
  assign halted   = halted_r;
  assign error    = error_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: vector table, corner-case sequences and a
// randomized program run against a program-walking reference model.
module tb_instr_fetch;

  localparam int         ADDR_W  = 5;
  localparam int         DATA_W  = 16;
  localparam int         TIMEOUT = 64;
  localparam logic [2:0] MVI_OP  = 3'b001;
  localparam logic [2:0] HALT_OP = 3'b111;

  logic              clock = 1'b0;
  logic              resetn;
  logic              enable;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [8:0]        ir;
  logic [DATA_W-1:0] din;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              error;

  logic [DATA_W-1:0] rom [32];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    int          dly;
    logic [8:0]  exp_ir;
    logic [15:0] exp_din;
    int          exp_lat;
    logic [4:0]  exp_pc;
  } vec_t;

  instr_fetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MVI_OP (MVI_OP),
    .HALT_OP(HALT_OP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (enable),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .ir      (ir),
    .din     (din),
    .run     (run),
    .done    (done),
    .pc      (pc),
    .halted  (halted),
    .error   (error)
  );

  always #5 clock = ~clock;

  // Synchronous program ROM: data valid one cycle after the address.
  always @(posedge clock) mem_data <= rom[mem_addr];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 32; a++) rom[a] = 16'h0000;
  endtask

  task automatic reset_dut();
    enable = 1'b0;
    done   = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    resetn = 1'b1;
  endtask

  // Returns the number of negedges until run is seen, or -1 if the budget runs out.
  task automatic wait_run(input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
      done = 1'b0;
    end while (!run && waited < budget);
    if (!run) waited = -1;
  endtask

  // Steps ncyc cycles answering every run with done after dly cycles.
  task automatic serve(input int ncyc, input int dly, output int runs);
    int pend;
    pend = -1;
    runs = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      done = 1'b0;
      if (run) begin
        runs++;
        pend = dly;
      end
      if (pend == 0) begin
        done = 1'b1;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
    end
    @(negedge clock);
    done = 1'b0;
  endtask

  initial begin
    vec_t              vecs [6];
    int                lat;
    int                runs;
    int                r2;
    int                n;
    int                waited;
    int                dly;
    int                elat;
    bit                got;
    bit                is_mvi;
    logic [4:0]        mpc;
    logic [4:0]        nxt;
    logic [15:0]       mdin;
    logic [15:0]       w;
    logic [2:0]        op;

    vecs[0] = '{16'h0500, 16'h0000, 2, 9'h00A, 16'h0000, 3, 5'd1};
    vecs[1] = '{16'h2000, 16'h1234, 0, 9'h040, 16'h1234, 5, 5'd2};
    vecs[2] = '{16'h4EFF, 16'hBEEF, 1, 9'h09D, 16'h0000, 3, 5'd1};
    vecs[3] = '{16'h3D55, 16'hFFFF, 3, 9'h07A, 16'hFFFF, 5, 5'd2};
    vecs[4] = '{16'hC080, 16'h1111, 5, 9'h181, 16'h0000, 3, 5'd1};
    vecs[5] = '{16'h3980, 16'h8001, 4, 9'h073, 16'h8001, 5, 5'd2};

    resetn = 1'b0;
    enable = 1'b0;
    done   = 1'b0;
    clear_rom();

    // Single-instruction programs from the vector table.
    for (int v = 0; v < 6; v++) begin
      clear_rom();
      rom[0] = vecs[v].w0;
      rom[1] = vecs[v].w1;
      reset_dut();
      enable = 1'b1;
      wait_run(12, lat);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      if (lat > 0) begin
        check($sformatf("vec%0d_ir", v), 32'(ir), 32'(vecs[v].exp_ir));
        check($sformatf("vec%0d_din", v), 32'(din), 32'(vecs[v].exp_din));
        check($sformatf("vec%0d_pc", v), 32'(pc), 32'(vecs[v].exp_pc));
        for (int k = 0; k <= vecs[v].dly; k++) begin
          if (k == vecs[v].dly) done = 1'b1;
          @(negedge clock);
          done = 1'b0;
          if (k == 0) check($sformatf("vec%0d_run_pulse", v), 32'(run), 32'd0);
        end
        check($sformatf("vec%0d_next_addr", v), 32'(mem_addr), 32'(vecs[v].exp_pc));
      end
    end

    // HALT opcode at address 2.
    clear_rom();
    rom[0] = 16'h0500;
    rom[1] = 16'h4EFF;
    rom[2] = 16'hE880;
    reset_dut();
    enable = 1'b1;
    serve(40, 0, runs);
    check("halt_runs", 32'(runs), 32'd2);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_error", 32'(error), 32'd0);
    check("halt_pc", 32'(pc), 32'd3);
    check("halt_ir", 32'(ir), 32'h1D1);
    serve(20, 0, runs);
    check("halt_stuck_runs", 32'(runs), 32'd0);
    check("halt_stuck_pc", 32'(pc), 32'd3);
    resetn = 1'b0;
    #1;
    check("halt_reset_pc", 32'(pc), 32'd0);
    check("halt_reset_halted", 32'(halted), 32'd0);

    // done never arrives: timeout.
    clear_rom();
    rom[0] = 16'h0500;
    reset_dut();
    enable = 1'b1;
    wait_run(12, lat);
    check("to_latency", 32'(lat), 32'd3);
    runs = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clock);
      if (run) runs++;
      if (k == TIMEOUT - 1) check("to_error_early", 32'(error), 32'd0);
    end
    check("to_error", 32'(error), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    serve(10, 0, r2);
    runs += r2;
    check("to_no_runs", 32'(runs), 32'd0);
    check("to_error_sticky", 32'(error), 32'd1);

    // mvi at 31 with its immediate at address 0.
    for (int a = 0; a < 31; a++) rom[a] = 16'h0A5C;
    rom[31] = 16'h2380;
    reset_dut();
    enable = 1'b1;
    n = 0;
    waited = 0;
    while (n < 32 && waited < 400) begin
      @(negedge clock);
      waited++;
      done = 1'b0;
      if (run) begin
        n++;
        if (n == 32) begin
          check("wrap_ir", 32'(ir), 32'h047);
          check("wrap_din", 32'(din), 32'h0A5C);
          check("wrap_pc", 32'(pc), 32'd1);
        end
        done = 1'b1;
      end
    end
    check("wrap_runs", 32'(n), 32'd32);
    @(negedge clock);
    done = 1'b0;
    check("wrap_next_addr", 32'(mem_addr), 32'd1);

    // enable dropped during WAIT, then async reset mid-WAIT.
    clear_rom();
    rom[0] = 16'h2000;
    rom[1] = 16'h5A5A;
    rom[2] = 16'h0500;
    reset_dut();
    enable = 1'b1;
    wait_run(12, lat);
    check("en_mvi_latency", 32'(lat), 32'd5);
    check("en_mvi_din", 32'(din), 32'h5A5A);
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    @(negedge clock);
    done = 1'b1;
    serve(8, 0, runs);
    check("en_idle_runs", 32'(runs), 32'd0);
    check("en_idle_pc", 32'(pc), 32'd2);
    check("en_idle_addr", 32'(mem_addr), 32'd2);
    enable = 1'b1;
    wait_run(12, lat);
    check("en_resume_latency", 32'(lat), 32'd3);
    check("en_resume_ir", 32'(ir), 32'h00A);
    check("en_resume_pc", 32'(pc), 32'd3);
    check("en_resume_din", 32'(din), 32'h5A5A);
    @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    check("async_run", 32'(run), 32'd0);
    check("async_pc", 32'(pc), 32'd0);
    check("async_ir", 32'(ir), 32'd0);
    check("async_din", 32'(din), 32'd0);
    check("async_halted", 32'(halted), 32'd0);
    check("async_error", 32'(error), 32'd0);

    // Random program walked by the reference model.
    for (int a = 0; a < 32; a++) begin
      op = 3'($urandom_range(0, 6));
      rom[a] = {op, 13'($urandom)};
    end
    reset_dut();
    enable = 1'b1;
    mpc  = 5'd0;
    mdin = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      w      = rom[mpc];
      is_mvi = (w[15:13] == MVI_OP);
      if (is_mvi) begin
        nxt  = mpc + 5'd1;
        mdin = rom[nxt];
        mpc  = mpc + 5'd2;
      end else begin
        mpc  = mpc + 5'd1;
      end
      elat   = is_mvi ? 5 : 3;
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 12) begin
        @(negedge clock);
        waited++;
        done = 1'b0;
        if (run) begin
          got = 1'b1;
        end else if (waited <= elat - 1 && $urandom_range(0, 3) == 0) begin
          done = 1'b1;
        end
      end
      check($sformatf("rnd%0d_latency", i), got ? 32'(waited) : 32'hFFFF_FFFF, 32'(elat));
      if (!got) break;
      check($sformatf("rnd%0d_ir", i), 32'(ir), 32'(w[15:7]));
      check($sformatf("rnd%0d_din", i), 32'(din), 32'(mdin));
      check($sformatf("rnd%0d_pc", i), 32'(pc), 32'(mpc));
      dly = $urandom_range(0, 6);
      for (int k = 0; k < dly; k++) @(negedge clock);
      done = 1'b1;
    end
    @(negedge clock);
    done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
